// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes and
// the ALU / PC / operand-select codes driven onto the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_ONE    = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory access and flags the cycle in which the
// access must be abandoned (still not ready with the count at TIMEOUT).
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 8'd0;
    end else if (!ready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute over a unified
// memory with a bounded wait, and counts retired instructions.
//
//   state     | meaning
//   FETCH     | read instruction, PC+1; wait for mem_ready
//   DECODE    | precompute branch target, dispatch on opcode
//   MEM_ADDR  | base + offset for lw/sw
//   MEM_READ  | data read; wait for mem_ready
//   MEM_WB    | load result to rt
//   MEM_WRITE | data write; wait for mem_ready
//   EXECUTE   | R-type ALU op
//   R_WB      | ALU result to rd
//   BRANCH    | compare, conditional PC update
//   JUMP      | PC <- jump target
//   ADDI_EX   | rs + immediate
//   ADDI_WB   | ALU result to rt
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic        mem_err,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        mem_err_q, mem_err_d;
  logic        retire;
  logic        timer_start;
  logic        expired;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .ready   (mem_ready),
    .expired (expired)
  );

  // The timer restarts whenever the FSM is not stalled in a wait state,
  // including the abort cycle, so a FETCH re-entered after a timeout starts at 0.
  assign timer_start = !is_wait_state(state_q) || mem_ready || expired;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d   = S_FETCH;
          mem_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EX;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          state_d   = S_FETCH;
          mem_err_d = 1'b1;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (expired) begin
          state_d   = S_FETCH;
          mem_err_d = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= 32'd0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_ALUOUT;
        pc_write  = (opcode == OP_BEQ) ? zero : ((opcode == OP_BNE) ? !zero : 1'b0);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_JUMP;
      end
      default: ;
    endcase
    // FETCH strobes follow mem_ready combinationally; hold them off during reset.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state      = state_q;
  assign retired    = retired_q;
  assign illegal_op = illegal_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, reset
// corner cases, and randomized instructions against a per-class path model.
module tb_multicycle_control;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        illegal_op, mem_err;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .illegal_op(illegal_op), .mem_err(mem_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] dut_outs();
    return {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // Output table per state, straight from the datapath control listing.
  function automatic logic [14:0] spec_out(input logic [3:0] st, input logic [5:0] op,
                                           input logic z, input logic rdy);
    logic pw, irw, io, mr, mw, rw, rd, m2r, sa;
    logic [1:0] sb, ao, ps;
    {pw, irw, io, mr, mw, rw, rd, m2r, sa} = '0;
    sb = 2'd0; ao = 2'd0; ps = 2'd0;
    case (st)
      4'd0:  begin mr = 1; sb = 2'd1; pw = rdy; irw = rdy; end
      4'd1:  sb = 2'd3;
      4'd2:  begin sa = 1; sb = 2'd2; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; io = 1; end
      4'd6:  begin sa = 1; ao = 2'd2; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin
        sa = 1; ao = 2'd1; ps = 2'd1;
        pw = (op == 6'h04) ? z : ((op == 6'h05) ? !z : 1'b0);
      end
      4'd9:  begin pw = 1; ps = 2'd2; end
      4'd10: begin sa = 1; sb = 2'd2; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pw, irw, io, mr, mw, rw, rd, m2r, sa, sb, ao, ps};
  endfunction

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        z;
    int          fw;
    int          mw;
    int          cycles;
    int          dret;
    logic        err;
    logic        ill;
    logic [31:0] seq;
  } vec_t;

  vec_t vecs[14];

  // Drives mem_ready by reacting to the DUT's wait states; ends when the DUT
  // comes back to FETCH (or signals a FETCH abort with mem_err).
  task automatic run_vec(input vec_t v);
    int cyc = 0;
    int waitcnt = 0;
    logic [3:0] st;
    logic [3:0] prev = 4'hF;
    logic [31:0] seq = 32'd0;
    logic [31:0] r0 = retired;
    bit done = 0;
    opcode = v.op;
    zero   = v.z;
    while (!done && cyc < 100) begin
      st = state;
      if (cyc > 0 && st == 4'd0 && (prev != 4'd0 || mem_err)) begin
        done = 1;
      end else begin
        if (st != prev) waitcnt = 0;
        if (st == 4'd0)                    mem_ready = (waitcnt >= v.fw);
        else if (st == 4'd3 || st == 4'd5) mem_ready = (waitcnt >= v.mw);
        else                               mem_ready = 1'($urandom_range(0, 1));
        seq = {seq[27:0], st};
        #2;
        check({v.name, " outs"}, {17'd0, dut_outs()}, {17'd0, spec_out(st, v.op, v.z, mem_ready)});
        @(posedge clk); #1;
        waitcnt++;
        prev = st;
        cyc++;
      end
    end
    check({v.name, " cycles"}, cyc, v.cycles);
    check({v.name, " seq"}, seq, v.seq);
    check({v.name, " retired"}, retired - r0, v.dret);
    check({v.name, " mem_err"}, {31'd0, mem_err}, {31'd0, v.err});
    check({v.name, " illegal"}, {31'd0, illegal_op}, {31'd0, v.ill});
  endtask

  typedef struct { logic [3:0] st; logic rdy; } cyc_t;
  cyc_t q[$];

  task automatic push_cyc(input logic [3:0] st);
    q.push_back('{st, 1'($urandom_range(0, 1))});
  endtask

  task automatic push_wait(input logic [3:0] st, input int w, output bit timed);
    timed = (w > TO);
    if (timed) begin
      for (int i = 0; i <= TO; i++) q.push_back('{st, 1'b0});
    end else begin
      for (int i = 0; i < w; i++) q.push_back('{st, 1'b0});
      q.push_back('{st, 1'b1});
    end
  endtask

  // Path of one instruction by class, with memory stalls of fw/mw cycles.
  task automatic model_instr(input logic [5:0] op, input int fw, input int mw,
                             output bit timed, output bit retire, output bit illegal);
    q.delete();
    retire = 0;
    illegal = 0;
    push_wait(4'd0, fw, timed);
    if (timed) return;
    push_cyc(4'd1);
    case (op)
      6'h00: begin push_cyc(4'd6); push_cyc(4'd7); retire = 1; end
      6'h23: begin
        push_cyc(4'd2);
        push_wait(4'd3, mw, timed);
        if (!timed) begin push_cyc(4'd4); retire = 1; end
      end
      6'h2B: begin
        push_cyc(4'd2);
        push_wait(4'd5, mw, timed);
        retire = !timed;
      end
      6'h04, 6'h05: begin push_cyc(4'd8); retire = 1; end
      6'h02: begin push_cyc(4'd9); retire = 1; end
      6'h08: begin push_cyc(4'd10); push_cyc(4'd11); retire = 1; end
      default: illegal = 1;
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h05 || op == 6'h02 || op == 6'h08;
  endfunction

  function automatic int rand_wait();
    int r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r < 8) return int'($urandom_range(4, TO));
    if (r == 8) return TO;
    return TO + 1;
  endfunction

  initial begin
    logic [5:0] legal_ops[7];
    logic [5:0] op;
    logic       z;
    int         fw, mw;
    bit         timed, ret, ill;
    bit         pending_err;
    logic [31:0] m_retired;
    logic        m_illegal;

    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};

    vecs[0]  = '{"rtype",     6'h00, 1'b0, 0,      0,      4,  1, 1'b0, 1'b0, 32'h0000_0167};
    vecs[1]  = '{"lw_wait3",  6'h23, 1'b0, 0,      3,      8,  1, 1'b0, 1'b0, 32'h0123_3334};
    vecs[2]  = '{"sw",        6'h2B, 1'b0, 0,      0,      4,  1, 1'b0, 1'b0, 32'h0000_0125};
    vecs[3]  = '{"beq_z1",    6'h04, 1'b1, 0,      0,      3,  1, 1'b0, 1'b0, 32'h0000_0018};
    vecs[4]  = '{"bne_z1",    6'h05, 1'b1, 0,      0,      3,  1, 1'b0, 1'b0, 32'h0000_0018};
    vecs[5]  = '{"beq_z0",    6'h04, 1'b0, 0,      0,      3,  1, 1'b0, 1'b0, 32'h0000_0018};
    vecs[6]  = '{"jump",      6'h02, 1'b0, 0,      0,      3,  1, 1'b0, 1'b0, 32'h0000_0019};
    vecs[7]  = '{"addi",      6'h08, 1'b0, 0,      0,      4,  1, 1'b0, 1'b0, 32'h0000_01AB};
    vecs[8]  = '{"fetch_to",  6'h00, 1'b0, TO,     0,      19, 1, 1'b0, 1'b0, 32'h0000_0167};
    vecs[9]  = '{"fetch_abort", 6'h00, 1'b0, TO+1, 0,      16, 0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[10] = '{"lw_abort",  6'h23, 1'b0, 0,      TO+1,   19, 0, 1'b1, 1'b0, 32'h3333_3333};
    vecs[11] = '{"sw_to",     6'h2B, 1'b0, 0,      TO,     19, 1, 1'b0, 1'b0, 32'h5555_5555};
    vecs[12] = '{"illegal",   6'h3F, 1'b0, 0,      0,      2,  0, 1'b0, 1'b1, 32'h0000_0001};
    vecs[13] = '{"rtype_ill", 6'h00, 1'b0, 0,      0,      4,  1, 1'b0, 1'b1, 32'h0000_0167};

    // Reset with memory ready: no strobes, everything cleared.
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst state", {28'd0, state}, 32'd0);
    check("rst strobes", {28'd0, pc_write, ir_write, mem_write, reg_write}, 32'd0);
    check("rst retired", retired, 32'd0);
    check("rst illegal", {31'd0, illegal_op}, 32'd0);
    check("rst mem_err", {31'd0, mem_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while stalled in MEM_WRITE.
    opcode = 6'h2B; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mw stall state", {28'd0, state}, 32'd5);
    check("mw stall strobe", {31'd0, mem_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mw rst state", {28'd0, state}, 32'd0);
    check("mw rst mem_write", {31'd0, mem_write}, 32'd0);
    check("mw rst illegal", {31'd0, illegal_op}, 32'd0);
    check("mw rst retired", retired, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // A full-length FETCH stall right after reset must not abort.
    run_vec('{"post_rst_to", 6'h00, 1'b0, TO, 0, 19, 1, 1'b0, 1'b0, 32'h0000_0167});

    // Randomized instruction stream against the path model.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_retired = 32'd0;
    m_illegal = 1'b0;
    pending_err = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      z  = 1'($urandom_range(0, 1));
      fw = rand_wait();
      mw = rand_wait();
      model_instr(op, fw, mw, timed, ret, ill);
      opcode = op;
      zero   = z;
      for (int i = 0; i < q.size(); i++) begin
        mem_ready = q[i].rdy;
        #2;
        check("rnd state", {28'd0, state}, {28'd0, q[i].st});
        check("rnd outs", {17'd0, dut_outs()}, {17'd0, spec_out(q[i].st, op, z, q[i].rdy)});
        check("rnd mem_err", {31'd0, mem_err}, {31'd0, (i == 0) ? pending_err : 1'b0});
        @(posedge clk); #1;
      end
      pending_err = timed;
      if (ret) m_retired = m_retired + 32'd1;
      if (ill) m_illegal = 1'b1;
      check("rnd retired", retired, m_retired);
      check("rnd illegal", {31'd0, illegal_op}, {31'd0, m_illegal});
    end
    #2;
    check("rnd final mem_err", {31'd0, mem_err}, {31'd0, pending_err});
    check("rnd final state", {28'd0, state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
